// File: rtl/uart_host_pkg.sv
// Shared constants for the UART host controller: register map, STATUS/CTRL
// bit positions and the transmit state encoding.
package uart_host_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LEVEL  = 2'd3;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_RX_OVERRUN  = 2;
    localparam int ST_TX_IDLE     = 3;
    localparam int ST_RX_FULL     = 4;
    localparam int ST_TX_OVERFLOW = 5;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RX_IE  = 1;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2,
        T_GAP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_host_ctrl_fifo.sv
// Synchronous FIFO with a combinational head output. The pointers carry one
// extra bit so that the difference between them gives the occupancy directly.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign count = wr_ptr_r - rd_ptr_r;
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == {CNT_W{1'b0}});
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // a push into a full FIFO is accepted only when a pop frees a slot that cycle
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // pointer update
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {CNT_W{1'b0}};
            rd_ptr_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + CNT_W'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + CNT_W'(1);
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side controller for the 8-bit UART core: byte-wide 4-register bus
// slave, TX/RX FIFOs, one-frame-at-a-time TX handshake and RX interrupt.
module uart_host_ctrl
    import uart_host_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bus_addr,
    input  logic       bus_wr,
    input  logic       bus_rd,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       irq,
    output logic       uart_en,
    output logic       uart_we,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_busy,
    input  logic       uart_tx_done,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_rx_data
);

    tx_state_t  state_r, next_s;
    logic       ctrl_en_r, ctrl_rx_ie_r;
    logic       rx_overrun_r, tx_overflow_r;
    logic [7:0] bus_rdata_r, rdata_s;
    logic       irq_r, uart_we_r;
    logic [7:0] uart_tx_data_r;

    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0]       tx_dout_s;
    logic [CNT_W-1:0] tx_count_s;
    logic             rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]       rx_dout_s;
    logic [CNT_W-1:0] rx_count_s;

    logic data_wr_s, status_wr_s, ctrl_wr_s, data_rd_s;
    logic tx_overflow_set_s, rx_overrun_set_s;
    logic [7:0] status_s;

    function automatic logic [3:0] sat_nibble(input logic [CNT_W-1:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        if (c32 > 32'd15) return 4'hF;
        else              return c32[3:0];
    endfunction

    assign data_wr_s   = bus_wr & (bus_addr == ADDR_DATA);
    assign status_wr_s = bus_wr & (bus_addr == ADDR_STATUS);
    assign ctrl_wr_s   = bus_wr & (bus_addr == ADDR_CTRL);
    assign data_rd_s   = bus_rd & (bus_addr == ADDR_DATA);

    // a write that finds TX full is dropped even if the FSM pops that cycle
    assign tx_push_s         = data_wr_s & ~tx_full_s;
    assign tx_overflow_set_s = data_wr_s & tx_full_s;
    assign rx_pop_s          = data_rd_s & ~rx_empty_s;
    assign rx_overrun_set_s  = uart_rx_done & rx_full_s & ~rx_pop_s;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .pop   (tx_pop_s),
        .din   (bus_wdata),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_done),
        .pop   (rx_pop_s),
        .din   (uart_rx_data),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    assign status_s = {2'b00, tx_overflow_r, rx_full_s,
                       (tx_empty_s & (state_r == T_IDLE)),
                       rx_overrun_r, tx_full_s, ~rx_empty_s};

    // TX next-state and FIFO pop
    always_comb begin
        next_s   = state_r;
        tx_pop_s = 1'b0;
        case (state_r)
            T_IDLE: begin
                if (ctrl_en_r && !tx_empty_s) begin
                    tx_pop_s = 1'b1;
                    next_s   = T_REQ;
                end else begin
                    next_s = T_IDLE;
                end
            end
            T_REQ: begin
                if (ctrl_en_r && uart_tx_busy) next_s = T_WAIT;
                else                           next_s = T_REQ;
            end
            T_WAIT: begin
                if (uart_tx_done) next_s = T_GAP;
                else              next_s = T_WAIT;
            end
            T_GAP: begin
                if (!uart_tx_busy) next_s = T_IDLE;
                else               next_s = T_GAP;
            end
            default: next_s = T_IDLE;
        endcase
    end

    // read data mux; an empty RX FIFO reads as zero
    always_comb begin
        rdata_s = 8'h00;
        case (bus_addr)
            ADDR_DATA:   rdata_s = rx_empty_s ? 8'h00 : rx_dout_s;
            ADDR_STATUS: rdata_s = status_s;
            ADDR_CTRL:   rdata_s = {6'b000000, ctrl_rx_ie_r, ctrl_en_r};
            ADDR_LEVEL:  rdata_s = {sat_nibble(rx_count_s), sat_nibble(tx_count_s)};
            default:     rdata_s = 8'h00;
        endcase
    end

    // TX state register; uart_we registered so it is high exactly in T_REQ
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= T_IDLE;
            uart_we_r      <= 1'b0;
            uart_tx_data_r <= 8'h00;
        end else begin
            state_r   <= next_s;
            uart_we_r <= (next_s == T_REQ);
            if (tx_pop_s) uart_tx_data_r <= tx_dout_s;
            else          uart_tx_data_r <= uart_tx_data_r;
        end
    end

    // control, sticky flags (set beats clear), read data and interrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_en_r     <= 1'b0;
            ctrl_rx_ie_r  <= 1'b0;
            rx_overrun_r  <= 1'b0;
            tx_overflow_r <= 1'b0;
            bus_rdata_r   <= 8'h00;
            irq_r         <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_en_r    <= bus_wdata[CTRL_ENABLE];
                ctrl_rx_ie_r <= bus_wdata[CTRL_RX_IE];
            end
            if (rx_overrun_set_s)                         rx_overrun_r <= 1'b1;
            else if (status_wr_s && bus_wdata[ST_RX_OVERRUN]) rx_overrun_r <= 1'b0;
            if (tx_overflow_set_s)                         tx_overflow_r <= 1'b1;
            else if (status_wr_s && bus_wdata[ST_TX_OVERFLOW]) tx_overflow_r <= 1'b0;
            if (bus_rd) bus_rdata_r <= rdata_s;
            irq_r <= ctrl_rx_ie_r & ~rx_empty_s;
        end
    end

    assign bus_rdata    = bus_rdata_r;
    assign irq          = irq_r;
    assign uart_en      = ctrl_en_r;
    assign uart_we      = uart_we_r;
    assign uart_tx_data = uart_tx_data_r;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed self-checking bench for uart_host_ctrl; inputs are driven and
// outputs sampled on the falling clock edge.
module tb_uart_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bus_addr;
    logic       bus_wr, bus_rd;
    logic [7:0] bus_wdata, bus_rdata;
    logic       irq, uart_en, uart_we;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy, uart_tx_done, uart_rx_done;
    logic [7:0] uart_rx_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_host_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_addr     (bus_addr),
        .bus_wr       (bus_wr),
        .bus_rd       (bus_rd),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .irq          (irq),
        .uart_en      (uart_en),
        .uart_we      (uart_we),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_done (uart_tx_done),
        .uart_rx_done (uart_rx_done),
        .uart_rx_data (uart_rx_data)
    );

    // all bus tasks start and end on a falling edge
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_addr = a; bus_rd = 1'b1;
        @(negedge clk);
        bus_rd = 1'b0;
        d = bus_rdata;
    endtask

    task automatic rx_push(input logic [7:0] d);
        uart_rx_data = d; uart_rx_done = 1'b1;
        @(negedge clk);
        uart_rx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] r;
        checks++; if ({bus_rdata, irq, uart_en, uart_we, uart_tx_data} !== 19'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {bus_rdata, irq, uart_en, uart_we, uart_tx_data});
        end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h08) begin errors++; $display("FAIL reset_status: got %h expected 08", r); end
        bus_read(2'd3, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_level: got %h expected 00", r); end
        bus_read(2'd2, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h expected 00", r); end
    endtask

    task automatic test_tx_basic();
        logic [7:0] r;
        bit seen;
        bus_write(2'd2, 8'h01);
        checks++; if (uart_en !== 1'b1) begin errors++; $display("FAIL tx_en: got %b expected 1", uart_en); end
        bus_write(2'd0, 8'h55);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge clk);
            if (uart_we === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL tx_we_rise: got %b expected 1 within 2 cycles", uart_we); end
        checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("FAIL tx_data: got %h expected 55", uart_tx_data); end
        repeat (3) @(negedge clk);
        checks++; if (uart_we !== 1'b1) begin errors++; $display("FAIL tx_we_hold: got %b expected 1", uart_we); end
        uart_tx_busy = 1'b1;
        @(negedge clk);
        checks++; if (uart_we !== 1'b0) begin errors++; $display("FAIL tx_we_drop: got %b expected 0", uart_we); end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL tx_status_busy: got %h expected 00", r); end
        uart_tx_done = 1'b1;
        @(negedge clk);
        uart_tx_done = 1'b0;
        @(negedge clk);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL tx_status_gap: got %h expected 00", r); end
        uart_tx_busy = 1'b0;
        @(negedge clk);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h08) begin errors++; $display("FAIL tx_status_idle: got %h expected 08", r); end
        checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("FAIL tx_data_hold: got %h expected 55", uart_tx_data); end
    endtask

    task automatic test_tx_overflow();
        logic [7:0] r;
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(i));
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL ovf_head: got %h expected 00", uart_tx_data); end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h02) begin errors++; $display("FAIL ovf_full_status: got %h expected 02", r); end
        bus_read(2'd3, r);
        checks++; if (r !== 8'h0F) begin errors++; $display("FAIL ovf_level: got %h expected 0f", r); end
        bus_write(2'd0, 8'h11);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h22) begin errors++; $display("FAIL ovf_sticky: got %h expected 22", r); end
        bus_write(2'd1, 8'h20);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h02) begin errors++; $display("FAIL ovf_clear: got %h expected 02", r); end
        checks++; if (uart_we !== 1'b0) begin errors++; $display("FAIL ovf_in_wait: got %b expected 0", uart_we); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        uart_tx_busy = 1'b0;
        checks++; if ({bus_rdata, irq, uart_en, uart_we, uart_tx_data} !== 19'd0) begin
            errors++; $display("FAIL mid_rst_outputs: got %h expected 0", {bus_rdata, irq, uart_en, uart_we, uart_tx_data});
        end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h08) begin errors++; $display("FAIL mid_rst_status: got %h expected 08", r); end
        bus_read(2'd3, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL mid_rst_level: got %h expected 00", r); end
    endtask

    task automatic test_rx_basic();
        logic [7:0] r;
        rx_push(8'hA3);
        bus_read(2'd3, r);
        checks++; if (r !== 8'h10) begin errors++; $display("FAIL rx_level: got %h expected 10", r); end
        bus_read(2'd0, r);
        checks++; if (r !== 8'hA3) begin errors++; $display("FAIL rx_data: got %h expected a3", r); end
        bus_read(2'd0, r);
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL rx_empty_read: got %h expected 00", r); end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h08) begin errors++; $display("FAIL rx_no_underflow: got %h expected 08", r); end
    endtask

    task automatic test_rx_full();
        logic [7:0] r;
        for (int i = 0; i < 16; i++) rx_push(8'h10 + 8'(i));
        bus_read(2'd1, r);
        checks++; if (r !== 8'h19) begin errors++; $display("FAIL rxf_status: got %h expected 19", r); end
        bus_read(2'd3, r);
        checks++; if (r !== 8'hF0) begin errors++; $display("FAIL rxf_level: got %h expected f0", r); end
        uart_rx_data = 8'h7E; uart_rx_done = 1'b1; bus_addr = 2'd0; bus_rd = 1'b1;
        @(negedge clk);
        uart_rx_done = 1'b0; bus_rd = 1'b0;
        checks++; if (bus_rdata !== 8'h10) begin errors++; $display("FAIL rxf_simul_data: got %h expected 10", bus_rdata); end
        bus_read(2'd1, r);
        checks++; if (r !== 8'h19) begin errors++; $display("FAIL rxf_simul_status: got %h expected 19", r); end
        rx_push(8'h7F);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h1D) begin errors++; $display("FAIL rxf_overrun: got %h expected 1d", r); end
        bus_write(2'd1, 8'h04);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h19) begin errors++; $display("FAIL rxf_clear: got %h expected 19", r); end
        uart_rx_data = 8'h80; uart_rx_done = 1'b1;
        bus_write(2'd1, 8'h04);
        uart_rx_done = 1'b0;
        bus_read(2'd1, r);
        checks++; if (r !== 8'h1D) begin errors++; $display("FAIL rxf_set_wins: got %h expected 1d", r); end
        for (int i = 1; i < 16; i++) begin
            bus_read(2'd0, r);
            checks++; if (r !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rxf_drain[%0d]: got %h expected %h", i, r, 8'h10 + 8'(i)); end
        end
        bus_read(2'd0, r);
        checks++; if (r !== 8'h7E) begin errors++; $display("FAIL rxf_drain_last: got %h expected 7e", r); end
        bus_write(2'd1, 8'h24);
        bus_read(2'd1, r);
        checks++; if (r !== 8'h08) begin errors++; $display("FAIL rxf_final_status: got %h expected 08", r); end
    endtask

    task automatic test_irq();
        logic [7:0] r;
        bus_write(2'd2, 8'h03);
        bus_read(2'd2, r);
        checks++; if (r !== 8'h03) begin errors++; $display("FAIL irq_ctrl: got %h expected 03", r); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
        rx_push(8'h42);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq); end
        bus_read(2'd0, r);
        checks++; if (r !== 8'h42) begin errors++; $display("FAIL irq_data: got %h expected 42", r); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
    endtask

    initial begin
        rst = 1'b0; bus_addr = 2'd0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wdata = 8'h00;
        uart_tx_busy = 1'b0; uart_tx_done = 1'b0; uart_rx_done = 1'b0; uart_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_reset_midframe();
        test_rx_basic();
        test_rx_full();
        test_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
